// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch requester (IF stage) and the data requester (MEM stage). Each
//   access is granted in IDLE, held on the memory port for MEM_LAT cycles
//   (ACCESS), then acknowledged with a one-cycle pulse (RESP). Data requests
//   win over fetch because the MEM stage holds the older instruction.
//
// Optional feature (compile-time macro MEMARB_FAIR_EN):
//   When defined, a streak counter limits consecutive data grants made while
//   fetch is waiting to STREAK_MAX; the next contested grant then goes to
//   fetch. When undefined, data priority is strict and fetch can starve.
//
// Parameters:
//   ADDR_W      address width
//   DATA_W      data width
//   MEM_LAT     memory latency in cycles, 1..15
//   STREAK_MAX  consecutive data grants allowed while fetch waits
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   if_req      fetch request, held until if_ack
//   if_addr     fetch address
//   if_ack      one-cycle fetch completion pulse
//   if_rdata    registered fetch data, held until next fetch completes
//   dm_req      data request, held until dm_ack
//   dm_we       data write enable (1 = write)
//   dm_addr     data address
//   dm_wdata    data write value
//   dm_ack      one-cycle data completion pulse (reads and writes)
//   dm_rdata    registered data read value, unchanged by writes
//   mem_en      memory access active
//   mem_we      memory write enable
//   mem_addr    memory address
//   mem_wdata   memory write data
//   mem_rdata   memory read data, valid in the last ACCESS cycle
//   busy        high in ACCESS and RESP
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STREAK_MAX < 1) begin : g_bad_cfg
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STREAK_MAX >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int unsigned    CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t             state;
  owner_t             owner;
  logic [CNT_W-1:0]   cnt;
  logic               grant_dm;
  logic               grant_if;

`ifdef MEMARB_FAIR_EN
  localparam int unsigned STREAK_W = (STREAK_MAX < 2) ? 1 : $clog2(STREAK_MAX + 1);

  logic [STREAK_W-1:0] streak;
  logic                fetch_due;

  // Fetch has waited through the maximum run of data grants.
  assign fetch_due = if_req && (streak == STREAK_W'(STREAK_MAX));
`endif

  // Grant decision is only acted on in IDLE.
  always_comb begin
    grant_dm = dm_req;
    grant_if = if_req && !dm_req;
`ifdef MEMARB_FAIR_EN
    if (fetch_due) begin
      grant_dm = 1'b0;
      grant_if = 1'b1;
    end
`endif
  end

`ifdef MEMARB_FAIR_EN
  // Counts data grants that made a waiting fetch wait longer; any fetch grant
  // or an uncontested data grant ends the streak.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (grant_if) begin
        streak <= '0;
      end else if (grant_dm) begin
        streak <= if_req ? streak + STREAK_W'(1) : '0;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      cnt       <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;

      unique case (state)
        IDLE: begin
          if (grant_dm || grant_if) begin
            state  <= ACCESS;
            busy   <= 1'b1;
            mem_en <= 1'b1;
            cnt    <= CNT_LOAD;
            if (grant_dm) begin
              owner     <= OWN_DM;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              owner     <= OWN_IF;
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            // mem_we still holds the latched write flag in this last cycle.
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
              dm_ack <= 1'b1;
            end
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Two instances: index 0 with MEM_LAT=1,
// index 1 with MEM_LAT=3, both with STREAK_MAX=2. Expected acknowledges are
// queued as stimulus is applied and retired by a monitor when acks appear;
// cycle-exact port behaviour is checked inline by the stimulus sequence.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst       [2];
  logic          if_req    [2];
  logic [AW-1:0] if_addr   [2];
  logic          if_ack    [2];
  logic [DW-1:0] if_rdata  [2];
  logic          dm_req    [2];
  logic          dm_we     [2];
  logic [AW-1:0] dm_addr   [2];
  logic [DW-1:0] dm_wdata  [2];
  logic          dm_ack    [2];
  logic [DW-1:0] dm_rdata  [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic          busy      [2];
  logic [3:0]    en_run    [2];

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          inst;
    bit          is_if;
    bit          is_wr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] exp_dm_last [2];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h8C02_0004;
      32'h0000_0200: return 32'h1234_5678;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .MEM_LAT   ((g == 0) ? 1 : 3),
      .STREAK_MAX(2)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ack   (if_ack[g]),
      .if_rdata (if_rdata[g]),
      .dm_req   (dm_req[g]),
      .dm_we    (dm_we[g]),
      .dm_addr  (dm_addr[g]),
      .dm_wdata (dm_wdata[g]),
      .dm_ack   (dm_ack[g]),
      .dm_rdata (dm_rdata[g]),
      .mem_en   (mem_en[g]),
      .mem_we   (mem_we[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy     (busy[g])
    );

    // Memory model: read data is valid only in the last cycle of an access.
    always @(posedge clk) en_run[g] <= (mem_en[g] === 1'b1) ? en_run[g] + 4'd1 : 4'd0;

    assign mem_rdata[g] = (mem_en[g] === 1'b1 && en_run[g] == ((g == 0) ? 4'd0 : 4'd2))
                          ? mem_model(mem_addr[g])
                          : (32'hBAD0_0000 | {16'h0, mem_addr[g][15:0]});
  end

  // Scoreboard retirement on every acknowledge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (if_ack[k] === 1'b1 || dm_ack[k] === 1'b1) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ack_inst", 64'(k), 64'(mon_e.inst));
          chk("ack_owner", {if_ack[k], dm_ack[k]}, {mon_e.is_if, !mon_e.is_if});
          if (mon_e.is_if) begin
            chk("if_rdata", if_rdata[k], mon_e.data);
          end else if (mon_e.is_wr) begin
            chk("dm_rdata_hold", dm_rdata[k], exp_dm_last[k]);
          end else begin
            chk("dm_rdata", dm_rdata[k], mon_e.data);
            exp_dm_last[k] = mon_e.data;
          end
        end
      end
    end
  end

  task automatic push_exp(input int k, input bit is_if, input bit is_wr, input logic [31:0] a);
    exp_t e;
    e.inst  = k;
    e.is_if = is_if;
    e.is_wr = is_wr;
    e.data  = is_wr ? 32'h0 : mem_model(a);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int k, input bit want_if, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      seen = want_if ? (if_ack[k] === 1'b1) : (dm_ack[k] === 1'b1);
    end
    chk("ack_timeout", 64'(seen), 64'd1);
  endtask

  task automatic wait_any(input int k, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      step();
      n++;
      seen = (if_ack[k] === 1'b1) || (dm_ack[k] === 1'b1);
    end
    chk("any_ack_timeout", 64'(seen), 64'd1);
  endtask

  task automatic chk_reset_outs(input int k);
    chk("rst_flags", {if_ack[k], dm_ack[k], mem_en[k], mem_we[k], busy[k]}, 64'd0);
    chk("rst_mem_addr", mem_addr[k], 64'd0);
    chk("rst_mem_wdata", mem_wdata[k], 64'd0);
    chk("rst_rdata", {if_rdata[k], dm_rdata[k]}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  fair;
    bit  ord_if [6];
    logic [31:0] da;
    logic [31:0] fa;

    for (int k = 0; k < 2; k++) begin
      rst[k]      = 1'b0;
      if_req[k]   = 1'b0;
      if_addr[k]  = '0;
      dm_req[k]   = 1'b0;
      dm_we[k]    = 1'b0;
      dm_addr[k]  = '0;
      dm_wdata[k] = '0;
      exp_dm_last[k] = '0;
    end

    // Reset with both requests pending on instance 0.
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h40;
    dm_req[0]  = 1'b1;
    dm_addr[0] = 32'h80;
    step();
    chk_reset_outs(0);
    chk_reset_outs(1);
    step();
    chk_reset_outs(0);
    chk_reset_outs(1);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    push_exp(0, 1'b0, 1'b0, 32'h80);
    push_exp(0, 1'b1, 1'b0, 32'h40);
    step();
    chk("first_grant_en", mem_en[0], 64'd1);
    chk("first_grant_addr", mem_addr[0], 64'h80);
    chk("first_grant_we", mem_we[0], 64'd0);
    wait_ack(0, 1'b0, n);
    chk("dm_ack_lat", 64'(n), 64'd1);
    dm_req[0] = 1'b0;
    wait_ack(0, 1'b1, n);
    chk("b2b_gap", 64'(n), 64'd3);
    if_req[0] = 1'b0;
    step();
    chk("idle_busy", busy[0], 64'd0);

    // Single fetch, MEM_LAT=1.
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h40;
    push_exp(0, 1'b1, 1'b0, 32'h40);
    step();
    chk("fetch_t1_en", mem_en[0], 64'd1);
    chk("fetch_t1_addr", mem_addr[0], 64'h40);
    chk("fetch_t1_we", mem_we[0], 64'd0);
    chk("fetch_t1_busy", busy[0], 64'd1);
    chk("fetch_t1_noack", if_ack[0], 64'd0);
    step();
    chk("fetch_t2_ack", if_ack[0], 64'd1);
    chk("fetch_t2_en", mem_en[0], 64'd0);
    chk("fetch_t2_rdata", if_rdata[0], 64'h8C02_0004);
    if_req[0] = 1'b0;
    step();
    chk("fetch_ack_pulse", if_ack[0], 64'd0);
    chk("fetch_idle_busy", busy[0], 64'd0);

    // Simultaneous fetch and data write: data first.
    if_req[0]   = 1'b1;
    if_addr[0]  = 32'h44;
    dm_req[0]   = 1'b1;
    dm_we[0]    = 1'b1;
    dm_addr[0]  = 32'h100;
    dm_wdata[0] = 32'hDEAD_BEEF;
    push_exp(0, 1'b0, 1'b1, 32'h100);
    push_exp(0, 1'b1, 1'b0, 32'h44);
    step();
    chk("sim_t1_en", mem_en[0], 64'd1);
    chk("sim_t1_we", mem_we[0], 64'd1);
    chk("sim_t1_addr", mem_addr[0], 64'h100);
    chk("sim_t1_wdata", mem_wdata[0], 64'hDEAD_BEEF);
    step();
    chk("sim_t2_acks", {dm_ack[0], if_ack[0]}, 64'b10);
    chk("sim_t2_dm_rdata", dm_rdata[0], mem_model(32'h80));
    dm_req[0] = 1'b0;
    dm_we[0]  = 1'b0;
    step();
    chk("sim_t3_en", mem_en[0], 64'd0);
    step();
    chk("sim_t4_en", mem_en[0], 64'd1);
    chk("sim_t4_addr", mem_addr[0], 64'h44);
    chk("sim_t4_we_wdata", {mem_we[0], mem_wdata[0]}, 64'd0);
    step();
    chk("sim_t5_ack", if_ack[0], 64'd1);
    if_req[0] = 1'b0;
    step();

    // MEM_LAT=3 read and write.
    dm_req[1]  = 1'b1;
    dm_we[1]   = 1'b0;
    dm_addr[1] = 32'h200;
    push_exp(1, 1'b0, 1'b0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat3_rd_en", mem_en[1], 64'd1);
      chk("lat3_rd_noack", dm_ack[1], 64'd0);
    end
    step();
    chk("lat3_rd_ack", dm_ack[1], 64'd1);
    chk("lat3_rd_en_off", mem_en[1], 64'd0);
    chk("lat3_rd_data", dm_rdata[1], 64'h1234_5678);
    dm_req[1] = 1'b0;
    step();
    dm_req[1]   = 1'b1;
    dm_we[1]    = 1'b1;
    dm_addr[1]  = 32'h300;
    dm_wdata[1] = 32'hCAFE_F00D;
    push_exp(1, 1'b0, 1'b1, 32'h300);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lat3_wr_we", {mem_en[1], mem_we[1]}, 64'b11);
      chk("lat3_wr_wdata", mem_wdata[1], 64'hCAFE_F00D);
    end
    step();
    chk("lat3_wr_ack", dm_ack[1], 64'd1);
    chk("lat3_wr_we_off", mem_we[1], 64'd0);
    dm_req[1] = 1'b0;
    dm_we[1]  = 1'b0;
    step();

    // Both requests held continuously on instance 0.
`ifdef MEMARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    for (int i = 0; i < 6; i++) ord_if[i] = fair && (i == 2 || i == 5);
    da = 32'h500;
    fa = 32'h600;
    for (int i = 0; i < 6; i++) begin
      if (ord_if[i]) begin
        push_exp(0, 1'b1, 1'b0, fa);
        fa = fa + 32'd4;
      end else begin
        push_exp(0, 1'b0, 1'b0, da);
        da = da + 32'd4;
      end
    end
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h600;
    dm_req[0]  = 1'b1;
    dm_addr[0] = 32'h500;
    for (int i = 0; i < 6; i++) begin
      wait_any(0, n);
      chk("fair_order", {if_ack[0], dm_ack[0]}, {ord_if[i], !ord_if[i]});
      chk("fair_gap", 64'(n), (i == 0) ? 64'd2 : 64'd3);
      if (if_ack[0] === 1'b1) if_addr[0] = if_addr[0] + 32'd4;
      if (dm_ack[0] === 1'b1) dm_addr[0] = dm_addr[0] + 32'd4;
    end
    dm_req[0] = 1'b0;
    if (!fair) begin
      push_exp(0, 1'b1, 1'b0, 32'h600);
      wait_ack(0, 1'b1, n);
      chk("starved_fetch_gap", 64'(n), 64'd3);
    end
    if_req[0] = 1'b0;
    step();
    step();

    // Reset during ACCESS on instance 1.
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h700;
    step();
    chk("abort_t1_en", mem_en[1], 64'd1);
    step();
    chk("abort_t2_en", mem_en[1], 64'd1);
    rst[1] = 1'b0;
    exp_dm_last[1] = '0;
    step();
    chk("abort_t3_flags", {mem_en[1], if_ack[1], busy[1]}, 64'd0);
    chk("abort_t3_dm_rdata", dm_rdata[1], 64'd0);
    chk("abort_t3_addr", mem_addr[1], 64'd0);
    rst[1]     = 1'b1;
    if_addr[1] = 32'h704;
    push_exp(1, 1'b1, 1'b0, 32'h704);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("refetch_en", mem_en[1], 64'd1);
      chk("refetch_addr", mem_addr[1], 64'h704);
    end
    step();
    chk("refetch_ack", if_ack[1], 64'd1);
    if_req[1] = 1'b0;
    step();
    step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the pipeline's instruction-fetch requester (IF stage) and its data requester (MEM stage), so the CPU runs on a unified program/data memory. The block arbitrates between the two, sequences each access through a fixed-latency memory port, and returns read data with a one-cycle acknowledge. Until it acks, the requesting stage stalls: IF holds PC and IF/ID, and MEM holds the EX/MEM-onward pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, memory read/write latency in cycles; legal range 1..15
- STREAK_MAX, 4, max consecutive data grants while fetch waits; used only with MEMARB_FAIR_EN

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- if_req  input  1  fetch request; held until if_ack
- if_addr  input  ADDR_W  fetch address; stable while if_req
- if_ack  output  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  output  DATA_W  registered fetch data; held until next fetch completes
- dm_req  input  1  data request; held until dm_ack
- dm_we  input  1  1 = write, 0 = read
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  write data
- dm_ack  output  1  one-cycle completion pulse for reads and writes
- dm_rdata  output  DATA_W  registered read data; unchanged by writes
- mem_en  output  1  memory access active
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data; valid in the last ACCESS cycle
- busy  output  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise pick an owner. Latch owner, address, we and wdata (wdata forced 0 and we forced 0 for fetch). Load cnt = MEM_LAT-1. Go to ACCESS.
- ACCESS:
  - mem_en=1. mem_we, mem_addr and mem_wdata are driven from the latched registers.
  - If cnt≠0, decrement cnt.
  - If cnt==0, capture mem_rdata into the owner's rdata register (reads only) and go to RESP.
  - mem_we is high for every ACCESS cycle of a write.
- RESP:
  - Owner's ack=1; mem_en=0. Go to IDLE.
  - Requests are not sampled in RESP.
- Priority: data beats fetch. The MEM stage is older, so this prevents pipeline deadlock.
- Requester drops req mid-access: the transaction still completes and the ack is still issued. The requester must ignore a stray ack.
- Request inputs are sampled only in IDLE. Later changes to them are ignored until the next grant.
- Reset mid-operation: the access is abandoned, no ack is issued, and a write may be partial. The requester re-issues.
- Reset values: state=IDLE, cnt=0. if_ack, dm_ack, mem_en, mem_we and busy = 0. mem_addr, mem_wdata, if_rdata and dm_rdata = 0. streak=0.

## Timing
- Request seen in IDLE at cycle t0:
  - mem_en is high for cycles t0+1 .. t0+MEM_LAT.
  - ack is at t0+MEM_LAT+1.
- The next grant is no earlier than t0+MEM_LAT+2. Peak throughput is one access per MEM_LAT+2 cycles.
- All outputs are registered; there is no combinational path from req to mem_* or to ack.
- if_rdata and dm_rdata update on the same edge that raises the matching ack.

## Configuration
- MEMARB_FAIR_EN defined:
  - A streak counter (width covers STREAK_MAX) counts consecutive data grants made while if_req=1.
  - When both requests are present and streak==STREAK_MAX, fetch wins.
  - streak clears on any fetch grant, and on any data grant made with if_req=0.
- MEMARB_FAIR_EN undefined:
  - No streak logic.
  - Strict data priority; fetch can starve while dm_req stays high.

## Test plan
- Reset: rst=0 for 2 cycles with if_req=dm_req=1 -> all outputs 0, no mem_en during reset. The first grant goes to data one cycle after rst=1.
- Single fetch, MEM_LAT=1: if_addr=0x40, memory returns 0x8C020004 -> at t1 mem_en=1, mem_addr=0x40, mem_we=0; at t2 if_ack=1, if_rdata=0x8C020004.
- Simultaneous requests, MEM_LAT=1: fetch 0x44 and data write 0x100/0xDEADBEEF both at t0 ->
  - t1: mem_we=1, mem_wdata=0xDEADBEEF.
  - t2: dm_ack=1, dm_rdata unchanged.
  - Fetch granted t3, if_ack at t5.
- MEM_LAT=3, data read 0x200, memory returns 0x12345678 -> mem_en high t1..t3; dm_ack and dm_rdata=0x12345678 at t4.
- Fairness: STREAK_MAX=2, both requests held continuously (each re-raised immediately after its ack) -> with MEMARB_FAIR_EN, grant order D,D,I,D,D,I; without it, only D grants.
- Reset in ACCESS, MEM_LAT=3: rst=0 at t2 -> mem_en=0 at t3, no ack; after release a fresh fetch completes at normal latency.
